// File: rtl/ddr2_port_arbiter_if.sv
// Request/return and memory command signals shared by the display reader, the pixel writer,
// the DDR2 manager and the port arbiter.
interface ddr2_port_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic              disp_rd_req;
  logic [ADDR_W-1:0] disp_rd_addr;
  logic [LEN_W-1:0]  disp_rd_len;
  logic              disp_rd_gnt;
  logic              disp_rd_valid;
  logic [DATA_W-1:0] disp_rd_data;
  logic              disp_rd_last;

  logic              frac_wr_req;
  logic [ADDR_W-1:0] frac_wr_addr;
  logic [DATA_W-1:0] frac_wr_data;
  logic              frac_wr_gnt;

  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_rd;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;

  // Arbiter side
  modport slave (
    input  disp_rd_req, disp_rd_addr, disp_rd_len,
    output disp_rd_gnt, disp_rd_valid, disp_rd_data, disp_rd_last,
    input  frac_wr_req, frac_wr_addr, frac_wr_data,
    output frac_wr_gnt,
    output mem_cmd_valid, mem_cmd_rd, mem_cmd_addr, mem_wr_data,
    input  mem_cmd_ready, mem_rd_valid, mem_rd_data
  );

  // Requesters and memory manager side
  modport master (
    output disp_rd_req, disp_rd_addr, disp_rd_len,
    input  disp_rd_gnt, disp_rd_valid, disp_rd_data, disp_rd_last,
    output frac_wr_req, frac_wr_addr, frac_wr_data,
    input  frac_wr_gnt,
    input  mem_cmd_valid, mem_cmd_rd, mem_cmd_addr, mem_wr_data,
    output mem_cmd_ready, mem_rd_valid, mem_rd_data
  );
endinterface

// File: rtl/ddr2_port_arbiter.sv
// Shares the DDR2 command port: display burst reads win, pixel writes are forced after STARVE_LIMIT
// display grants. Grant 1 cycle after request, returns forwarded 1 cycle late; commands hold while !ready.
module ddr2_port_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 32,
  parameter int RD_BURST_MAX = 8,
  parameter int LEN_W        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ddr2_port_arbiter_if.slave bus,
  output logic               busy,
  output logic               proto_err
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_ISSUE = 2'd1;
  localparam logic [1:0] RD_DRAIN = 2'd2;
  localparam logic [1:0] WR_ISSUE = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [LEN_W-1:0]  rd_len;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  returned;
  logic [SC_W-1:0]   starve_cnt;

  logic              force_wr;
  logic              rd_active;
  logic              rd_hit;
  logic              cmd_fire;
  logic [LEN_W-1:0]  len_clamp;
  logic [LEN_W-1:0]  issued_nxt;
  logic [LEN_W-1:0]  returned_nxt;

  always_comb begin
    len_clamp = bus.disp_rd_len;
    if (bus.disp_rd_len == '0)
      len_clamp = LEN_W'(1);
    else if (bus.disp_rd_len > LEN_W'(RD_BURST_MAX))
      len_clamp = LEN_W'(RD_BURST_MAX);
  end

  assign force_wr     = bus.frac_wr_req && (starve_cnt == SC_W'(STARVE_LIMIT));
  assign rd_active    = (state == RD_ISSUE) || (state == RD_DRAIN);
  // A return only counts while this burst still owes words; anything else is a protocol error.
  assign rd_hit       = bus.mem_rd_valid && rd_active && (returned != rd_len);
  assign returned_nxt = returned + {{(LEN_W-1){1'b0}}, rd_hit};
  assign issued_nxt   = issued + LEN_W'(1);
  assign cmd_fire     = bus.mem_cmd_valid && bus.mem_cmd_ready;

  assign bus.mem_cmd_valid = (state == RD_ISSUE) || (state == WR_ISSUE);
  assign bus.mem_cmd_rd    = (state == RD_ISSUE);
  assign bus.mem_cmd_addr  = (state == RD_ISSUE) ? base_addr + ADDR_W'(issued) :
                             (state == WR_ISSUE) ? wr_addr : '0;
  assign bus.mem_wr_data   = (state == WR_ISSUE) ? wr_data : '0;
  assign busy              = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      base_addr         <= '0;
      wr_addr           <= '0;
      wr_data           <= '0;
      rd_len            <= '0;
      issued            <= '0;
      returned          <= '0;
      starve_cnt        <= '0;
      proto_err         <= 1'b0;
      bus.disp_rd_gnt   <= 1'b0;
      bus.frac_wr_gnt   <= 1'b0;
      bus.disp_rd_valid <= 1'b0;
      bus.disp_rd_data  <= '0;
      bus.disp_rd_last  <= 1'b0;
    end else begin
      bus.disp_rd_gnt   <= 1'b0;
      bus.frac_wr_gnt   <= 1'b0;
      bus.disp_rd_valid <= rd_hit;
      bus.disp_rd_last  <= rd_hit && (returned_nxt == rd_len);
      if (rd_hit)
        bus.disp_rd_data <= bus.mem_rd_data;
      if (bus.mem_rd_valid && !rd_hit)
        proto_err <= 1'b1;
      returned <= returned_nxt;

      case (state)
        IDLE: begin
          if (bus.disp_rd_req && !force_wr) begin
            state           <= RD_ISSUE;
            base_addr       <= bus.disp_rd_addr;
            rd_len          <= len_clamp;
            issued          <= '0;
            returned        <= '0;
            bus.disp_rd_gnt <= 1'b1;
            if (!bus.frac_wr_req)
              starve_cnt <= '0;
            else if (starve_cnt != SC_W'(STARVE_LIMIT))
              starve_cnt <= starve_cnt + SC_W'(1);
          end else if (bus.frac_wr_req) begin
            state           <= WR_ISSUE;
            wr_addr         <= bus.frac_wr_addr;
            wr_data         <= bus.frac_wr_data;
            bus.frac_wr_gnt <= 1'b1;
            starve_cnt      <= '0;
          end
        end
        RD_ISSUE: begin
          if (cmd_fire) begin
            issued <= issued_nxt;
            if (issued_nxt == rd_len)
              state <= (returned_nxt == rd_len) ? IDLE : RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (returned == rd_len)
            state <= IDLE;
        end
        WR_ISSUE: begin
          if (cmd_fire)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Bench for ddr2_port_arbiter: directed vector table, hand-written corner sequences and
// random single transactions checked against an address-arithmetic model of the port.
module tb_ddr2_port_arbiter;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic proto_err;

  ddr2_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus();

  ddr2_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_BURST_MAX(8), .LEN_W(LEN_W), .STARVE_LIMIT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory responder / monitor state (written only by the responder process)
  int                cyc = 0;
  logic [ADDR_W-1:0] cmd_addr[$];
  bit                cmd_rd[$];
  logic [DATA_W-1:0] cmd_data[$];
  int                cmd_cyc[$];
  logic [DATA_W-1:0] ret_data[$];
  bit                ret_last[$];
  int                ret_cyc[$];
  int                hold_viol = 0;
  logic [ADDR_W-1:0] pend_addr[$];
  int                pend_due[$];
  int                seen_stray = 0;
  bit                pv = 1'b0;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  bit                p_rd;

  // Responder controls (written only by the main sequence)
  int lat        = 3;
  int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
  int stray_gen  = 0;

  function automatic logic [DATA_W-1:0] rdat(input logic [ADDR_W-1:0] a);
    return {a[9:0], a} ^ 32'hC3A5_0F0F;
  endfunction

  initial begin : responder
    bus.mem_cmd_ready = 1'b1;
    bus.mem_rd_valid  = 1'b0;
    bus.mem_rd_data   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && (!bus.mem_cmd_valid || bus.mem_cmd_addr !== p_addr || bus.mem_cmd_rd !== p_rd ||
                   (!p_rd && bus.mem_wr_data !== p_data)))
          hold_viol++;
        pv     = bus.mem_cmd_valid && !bus.mem_cmd_ready;
        p_addr = bus.mem_cmd_addr;
        p_rd   = bus.mem_cmd_rd;
        p_data = bus.mem_wr_data;
        if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
          cmd_addr.push_back(bus.mem_cmd_addr);
          cmd_rd.push_back(bus.mem_cmd_rd);
          cmd_data.push_back(bus.mem_wr_data);
          cmd_cyc.push_back(cyc);
          if (bus.mem_cmd_rd) begin
            pend_addr.push_back(bus.mem_cmd_addr);
            pend_due.push_back(cyc + lat);
          end
        end
        if (bus.disp_rd_valid) begin
          ret_data.push_back(bus.disp_rd_data);
          ret_last.push_back(bus.disp_rd_last);
          ret_cyc.push_back(cyc);
        end
      end
      @(posedge clk);
      #2;
      cyc++;
      bus.mem_cmd_ready = (ready_mode == 0) ? 1'b1 :
                          (ready_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (stray_gen != seen_stray) begin
        seen_stray       = stray_gen;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 32'hBAD0_BAD0;
      end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = rdat(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.mem_rd_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit rd, output bit ok, output int gcyc);
    ok = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rd ? bus.disp_rd_gnt : bus.frac_wr_gnt) begin
        ok = 1'b1;
        gcyc = cyc;
        return;
      end
    end
  endtask

  task automatic wait_idle(output bit ok, output int icyc);
    ok = 1'b0;
    icyc = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        icyc = cyc;
        return;
      end
    end
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic do_txn(input bit rd, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                        input logic [DATA_W-1:0] wdat, output int gcyc, output int icyc);
    bit ok;
    tick();
    if (rd) begin
      bus.disp_rd_req  = 1'b1;
      bus.disp_rd_addr = addr;
      bus.disp_rd_len  = len;
    end else begin
      bus.frac_wr_req  = 1'b1;
      bus.frac_wr_addr = addr;
      bus.frac_wr_data = wdat;
    end
    wait_gnt(rd, ok, gcyc);
    check(rd ? "rd_gnt_seen" : "wr_gnt_seen", 32'(ok), 32'd1);
    tick();
    bus.disp_rd_req = 1'b0;
    bus.frac_wr_req = 1'b0;
    wait_idle(ok, icyc);
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  // Reference: a read of len words is clamp(len) commands at consecutive wrapped addresses,
  // each returned in order with last on the final word; a write is one command, no returns.
  task automatic model_check(input string tag, input bit rd, input logic [ADDR_W-1:0] addr,
                             input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] wdat,
                             input int c0, input int r0);
    int n;
    int bad;
    logic [ADDR_W-1:0] e;
    n = !rd ? 1 : (len == 0) ? 1 : (len > 8) ? 8 : int'(len);
    check({tag, " ncmd"}, 32'(cmd_addr.size() - c0), 32'(n));
    check({tag, " nret"}, 32'(ret_data.size() - r0), rd ? 32'(n) : 32'd0);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      e = addr + ADDR_W'(i);
      if (c0 + i < cmd_addr.size())
        if (cmd_addr[c0+i] !== e || cmd_rd[c0+i] !== rd || (!rd && cmd_data[c0+i] !== wdat))
          bad++;
      if (rd && r0 + i < ret_data.size())
        if (ret_data[r0+i] !== rdat(e) || ret_last[r0+i] !== (i == n - 1))
          bad++;
    end
    check({tag, " content"}, 32'(bad), 32'd0);
  endtask

  task automatic count_until_frac(output int nd, output bit ok);
    nd = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.disp_rd_gnt) nd++;
      if (bus.frac_wr_gnt) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    bit                rd;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] wdat;
    int                exp_n;
    logic [ADDR_W-1:0] exp_first;
    logic [ADDR_W-1:0] exp_last;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int g, ic, c0, r0, nd, bad, lastc;
    bit ok, rd;
    string tag;
    logic [ADDR_W-1:0] ra;
    logic [LEN_W-1:0]  rl;
    logic [DATA_W-1:0] rw;

    vecs[0] = '{1'b1, 22'h0001F0, 4'd4,  32'h0,         4, 22'h0001F0, 22'h0001F3};
    vecs[1] = '{1'b1, 22'h000100, 4'd0,  32'h0,         1, 22'h000100, 22'h000100};
    vecs[2] = '{1'b1, 22'h000200, 4'd12, 32'h0,         8, 22'h000200, 22'h000207};
    vecs[3] = '{1'b1, 22'h3FFFFE, 4'd4,  32'h0,         4, 22'h3FFFFE, 22'h000001};
    vecs[4] = '{1'b0, 22'h012345, 4'd0,  32'hDEADBEEF,  1, 22'h012345, 22'h012345};
    vecs[5] = '{1'b1, 22'h2AAAA0, 4'd8,  32'h0,         8, 22'h2AAAA0, 22'h2AAAA7};
    vecs[6] = '{1'b1, 22'h3FFFFF, 4'd15, 32'h0,         8, 22'h3FFFFF, 22'h000006};
    vecs[7] = '{1'b0, 22'h3FFFFF, 4'd0,  32'h00000000,  1, 22'h3FFFFF, 22'h3FFFFF};

    rst_n            = 1'b0;
    bus.disp_rd_req  = 1'b0;
    bus.disp_rd_addr = '0;
    bus.disp_rd_len  = '0;
    bus.frac_wr_req  = 1'b0;
    bus.frac_wr_addr = '0;
    bus.frac_wr_data = '0;

    // Reset state
    @(negedge clk);
    check("reset cmd_valid", 32'(bus.mem_cmd_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset gnts", {30'd0, bus.disp_rd_gnt, bus.frac_wr_gnt}, 32'd0);
    check("reset rd_valid_last", {30'd0, bus.disp_rd_valid, bus.disp_rd_last}, 32'd0);
    check("reset rd_data", bus.disp_rd_data, 32'd0);
    check("reset proto_err", 32'(proto_err), 32'd0);
    tick();
    rst_n = 1'b1;

    // Directed vectors: always ready, 3-cycle return latency
    for (int v = 0; v < 8; v++) begin
      c0 = cmd_addr.size();
      r0 = ret_data.size();
      do_txn(vecs[v].rd, vecs[v].addr, vecs[v].len, vecs[v].wdat, g, ic);
      tag = $sformatf("vec%0d", v);
      check({tag, " ncmd"}, 32'(cmd_addr.size() - c0), 32'(vecs[v].exp_n));
      check({tag, " first_addr"}, (cmd_addr.size() > c0) ? 32'(cmd_addr[c0]) : 32'hFFFF_FFFF,
            32'(vecs[v].exp_first));
      check({tag, " last_addr"}, (cmd_addr.size() > c0) ? 32'(cmd_addr[cmd_addr.size()-1]) : 32'hFFFF_FFFF,
            32'(vecs[v].exp_last));
      check({tag, " gnt_with_first_cmd"}, (cmd_cyc.size() > c0) ? 32'(cmd_cyc[c0]) : 32'hFFFF_FFFF, 32'(g));
      if (vecs[v].rd) begin
        check({tag, " cmds_back_to_back"},
              (cmd_cyc.size() > c0) ? 32'(cmd_cyc[cmd_cyc.size()-1] - cmd_cyc[c0]) : 32'hFFFF_FFFF,
              32'(vecs[v].exp_n - 1));
        lastc = (ret_cyc.size() > r0) ? ret_cyc[ret_cyc.size()-1] : -10;
        check({tag, " busy_drop_after_last"}, 32'(ic), 32'(lastc + 1));
      end
      model_check(tag, vecs[v].rd, vecs[v].addr, vecs[v].len, vecs[v].wdat, c0, r0);
    end

    // Write under 5+ cycles of backpressure: command held stable, accepted exactly once
    c0 = cmd_addr.size();
    tick();
    ready_mode       = 1;
    bus.frac_wr_req  = 1'b1;
    bus.frac_wr_addr = 22'h0ABCDE;
    bus.frac_wr_data = 32'h5A5A_1234;
    wait_gnt(1'b0, ok, g);
    check("bp wr_gnt_seen", 32'(ok), 32'd1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (!(bus.mem_cmd_valid && !bus.mem_cmd_rd && bus.mem_cmd_addr == 22'h0ABCDE &&
            bus.mem_wr_data == 32'h5A5A_1234))
        bad++;
      tick();
      if (i == 0) bus.frac_wr_req = 1'b0;
      @(negedge clk);
    end
    check("bp cmd_stable", 32'(bad), 32'd0);
    check("bp no_accept_while_stalled", 32'(cmd_addr.size() - c0), 32'd0);
    tick();
    ready_mode = 0;
    wait_idle(ok, ic);
    check("bp idle_reached", 32'(ok), 32'd1);
    check("bp ncmd", 32'(cmd_addr.size() - c0), 32'd1);
    check("bp wdata", (cmd_data.size() > c0) ? cmd_data[c0] : 32'hFFFF_FFFF, 32'h5A5A_1234);

    // Stray return in IDLE sets sticky proto_err and produces no display data
    r0 = ret_data.size();
    check("stray proto_err_before", 32'(proto_err), 32'd0);
    tick();
    stray_gen++;
    repeat (3) @(negedge clk);
    check("stray proto_err_set", 32'(proto_err), 32'd1);
    check("stray no_rd_valid", 32'(ret_data.size() - r0), 32'd0);
    c0 = cmd_addr.size();
    r0 = ret_data.size();
    do_txn(1'b1, 22'h000040, 4'd2, 32'h0, g, ic);
    model_check("after_stray", 1'b1, 22'h000040, 4'd2, 32'h0, c0, r0);
    check("stray proto_err_sticky", 32'(proto_err), 32'd1);

    // Reset in the middle of a burst; late returns after release flag proto_err
    lat = 6;
    tick();
    bus.disp_rd_req  = 1'b1;
    bus.disp_rd_addr = 22'h000400;
    bus.disp_rd_len  = 4'd8;
    wait_gnt(1'b1, ok, g);
    check("rstmid gnt_seen", 32'(ok), 32'd1);
    tick();
    bus.disp_rd_req = 1'b0;
    tick();
    tick();
    check("rstmid in_issue", {30'd0, busy, bus.mem_cmd_valid}, 32'd3);
    rst_n = 1'b0;
    #2;
    check("rstmid cmd_valid", 32'(bus.mem_cmd_valid), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid rd_valid", 32'(bus.disp_rd_valid), 32'd0);
    check("rstmid proto_err_cleared", 32'(proto_err), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid idle_after_release", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("rstmid late_return_err", 32'(proto_err), 32'd1);
    check("rstmid stays_idle", 32'(busy), 32'd0);

    // Starvation: both held, write forced after exactly 16 display grants
    lat = 3;
    do_reset();
    @(negedge clk);
    check("starve proto_err_reset", 32'(proto_err), 32'd0);
    tick();
    bus.disp_rd_req  = 1'b1;
    bus.disp_rd_addr = 22'h000100;
    bus.disp_rd_len  = 4'd1;
    bus.frac_wr_req  = 1'b1;
    bus.frac_wr_addr = 22'h02BEEF;
    bus.frac_wr_data = 32'hCAFE_F00D;
    count_until_frac(nd, ok);
    check("starve frac_gnt_seen", 32'(ok), 32'd1);
    check("starve disp_grants_before", 32'(nd), 32'd16);
    tick();
    bus.frac_wr_req = 1'b0;
    wait_gnt(1'b1, ok, g);
    check("starve display_resumes", 32'(ok), 32'd1);
    tick();
    bus.frac_wr_req = 1'b1;
    count_until_frac(nd, ok);
    check("starve2 frac_gnt_seen", 32'(ok), 32'd1);
    check("starve2 counter_restarted", 32'(nd), 32'd16);
    tick();
    bus.disp_rd_req = 1'b0;
    bus.frac_wr_req = 1'b0;
    wait_idle(ok, ic);
    check("starve idle_reached", 32'(ok), 32'd1);

    // Random single transactions with random backpressure and latency
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      lat = $urandom_range(1, 6);
      rd  = ($urandom_range(0, 2) != 0);
      ra  = ADDR_W'($urandom);
      rl  = LEN_W'($urandom_range(0, 15));
      rw  = $urandom;
      c0  = cmd_addr.size();
      r0  = ret_data.size();
      do_txn(rd, ra, rl, rw, g, ic);
      model_check($sformatf("rnd%0d", i), rd, ra, rl, rw, c0, r0);
    end
    ready_mode = 0;
    repeat (4) @(negedge clk);
    check("cmd_hold_while_not_ready", 32'(hold_viol), 32'd0);
    check("final proto_err_clean", 32'(proto_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
